time_unit_counter: RTL and testbench
====================================

Name: time_unit_counter

Overview:
Parametrised modulo counter for one clock/calendar field (second, minute, hour, day, month). Generalises the fixed 0..23 hour counter with these additions:
- configurable MIN/MAX range;
- runtime upper bound (days-in-month);
- clamping when the bound drops;
- single-clock synchronous adjust with button edge detection.

Instances chain via carry_in/carry_out to form the full timekeeping path.

Parameters:
WIDTH, 5, counter width in bits
MIN_VAL, 0, lowest legal value (1 for day/month)
MAX_VAL, 23, highest legal value; rule MIN_VAL <= RESET_VAL <= MAX_VAL < 2**WIDTH
RESET_VAL, 0, value loaded on reset
REPEAT_DELAY, 4, cycles a button is held before auto-repeat (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 2, cycles between auto-repeat steps (AUTO_REPEAT_EN only)

Ports:
clk_1Hz  in  1  sole clock; all state on rising edge
rst_n  in  1  synchronous reset, active-low
en_1  in  1  count enable tick
carry_in  in  1  carry from the lower field; count only when high
adjust  in  1  0 = count mode, 1 = adjust mode
up  in  1  increment button level, already debounced, clk_1Hz domain
down  in  1  decrement button level, same domain
dyn_max  in  WIDTH  runtime upper bound; tie to MAX_VAL if unused
value  out  WIDTH  current count, registered
carry_out  out  1  one-cycle pulse on count-mode wrap, registered
at_max  out  1  combinational: value == eff_max

Behaviour:
- Reset is synchronous and active-low: when rst_n = 0 at a clock edge, value <= RESET_VAL, carry_out <= 0, up_q <= 0, down_q <= 0, hold counters <= 0.
- eff_max (combinational):
  - min(dyn_max, MAX_VAL);
  - forced to MIN_VAL if that result is < MIN_VAL.
- Edge detect:
  - up_q/down_q sample up/down every cycle, regardless of adjust.
  - up_rise = up & ~up_q; down_rise = down & ~down_q.
  - Button held high when leaving reset counts as one edge.
  - Entering adjust while a button is held gives no edge.
- Priority per cycle, highest first:
  1. Count mode (adjust = 0) with en_1 & carry_in:
     - if value >= eff_max: value <= MIN_VAL, carry_out <= 1;
     - else value <= value + 1.
  2. Count mode, no count event, value > eff_max: value <= eff_max (clamp), no carry.
  3. Adjust mode:
     - up_rise only: value <= MIN_VAL if value >= eff_max, else value + 1;
     - down_rise only: value <= eff_max if value <= MIN_VAL, else value - 1;
     - both rising in the same cycle: no change;
     - value > eff_max with no step: clamp as in item 2.
  4. Otherwise hold.
- carry_out:
  - 0 in every cycle not matching item 1's wrap;
  - never asserted in adjust mode;
  - en_1/carry_in are ignored in adjust mode (carries from below are dropped).
- Arithmetic is WIDTH bits. Compares are unsigned. No intermediate overflow occurs because MAX_VAL < 2**WIDTH.
- Latency: one cycle from the qualifying input to the value/carry_out change.

Optional Feature:
AUTO_REPEAT_EN:
- Defined:
  - In adjust mode, while a button stays high, hold_cnt counts cycles since its rising edge (edge cycle = 0).
  - An extra step fires when hold_cnt >= REPEAT_DELAY and (hold_cnt - REPEAT_DELAY) mod REPEAT_PERIOD == 0.
  - hold_cnt saturates safely.
  - Both buttons held: no repeat steps.
  - hold_cnt clears on release or when adjust = 0.
- Undefined: only rising edges step. Hold counters and REPEAT_* parameters have no effect.

Decomposition:
- Package time_pkg:
  - field width constants (SEC_W = 6, HOUR_W = 5, DAY_W = 5, ...);
  - per-field MIN/MAX constants;
  - adjust mode encoding.
- Sub-module btn_step_gen:
  - edge detect plus optional repeat for one button;
  - outputs a one-cycle step pulse;
  - instantiated twice (up, down).

Test Plan:
1. MIN 0, MAX 23, value 23, adjust = 0, en_1 = carry_in = 1 for one cycle -> value 0, carry_out = 1 for exactly one cycle. Next cycle: carry_out 0.
2. MIN 1, MAX 31, value 31, dyn_max changes 31 -> 30, no count event -> value 30 next cycle, carry_out 0. Then one count event -> value 1, carry_out 1.
3. adjust = 1, value 23, single up pulse -> value 0, carry_out 0. Down pulse at value 0 -> 23. en_1 = carry_in = 1 during adjust -> value unchanged.
4. adjust = 1: up and down rise in the same cycle -> value unchanged. Up held high 10 cycles (macro undefined) -> exactly one step (5 -> 6).
5. Count event and rst_n = 0 in the same cycle, RESET_VAL 0 -> value 0, carry_out 0. Release reset with up held and adjust = 1 -> one step on the first cycle.
6. AUTO_REPEAT_EN, DELAY 4, PERIOD 2, value 5, up high cycles 0..9 -> steps at cycles 0, 4, 6, 8 -> value 9 after release.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants for the timekeeping field counters.
// Field widths, per-field legal ranges and the adjust-mode encoding used by
// time_unit_counter instances that chain into a full clock/calendar.
package time_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;

  localparam int SEC_MIN  = 0;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MIN  = 0;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MIN = 0;
  localparam int HOUR_MAX = 23;
  localparam int DAY_MIN  = 1;
  localparam int DAY_MAX  = 31;
  localparam int MON_MIN  = 1;
  localparam int MON_MAX  = 12;

  typedef enum logic {
    MODE_COUNT  = 1'b0,
    MODE_ADJUST = 1'b1
  } mode_e;

endpackage

// File: rtl/time_unit_counter_if.sv
// Control/status bundle of one time_unit_counter field.
// master: the controller side (drives count/adjust controls, reads status).
// slave : the counter side.
//   en_1, carry_in : count tick and carry from the lower field
//   adjust         : 0 = count mode, 1 = adjust mode
//   up, down       : debounced button levels
//   dyn_max        : runtime upper bound
//   value          : current count (registered)
//   carry_out      : one-cycle wrap pulse (registered)
//   at_max         : value == effective maximum (combinational)
interface time_unit_counter_if #(
  parameter int WIDTH = 5
);
  logic             en_1;
  logic             carry_in;
  logic             adjust;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] dyn_max;
  logic [WIDTH-1:0] value;
  logic             carry_out;
  logic             at_max;

  modport master (
    output en_1, carry_in, adjust, up, down, dyn_max,
    input  value, carry_out, at_max
  );

  modport slave (
    input  en_1, carry_in, adjust, up, down, dyn_max,
    output value, carry_out, at_max
  );
endinterface

// File: rtl/btn_step_gen.sv
// Turns one debounced button level into a one-cycle step pulse.
// A rising edge always steps. With AUTO_REPEAT_EN defined, holding the
// button in adjust mode adds repeat steps after REPEAT_DELAY cycles, then
// every REPEAT_PERIOD cycles; inhibit (other button held) blocks repeats.
//   clk, rst_n : clock, synchronous active-low reset
//   btn        : button level
//   adjust     : adjust mode (enables repeat counting)
//   inhibit    : suppress repeat steps
//   step       : one-cycle step pulse
module btn_step_gen #(
  parameter int REPEAT_DELAY  = 4,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic adjust,
  input  logic inhibit,
  output logic step
);

  if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_step_gen: REPEAT_DELAY must be >= 0 and REPEAT_PERIOD >= 1");
  end

  logic btn_q;
  logic rise;
  assign rise = btn & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [CW-1:0] DLY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] LAST = CW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  // Once past the delay the count cycles DLY..LAST instead of growing, so it
  // never overflows and a repeat fires each time it lands on DLY.
  logic          active;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] cur_cnt;
  logic [CW-1:0] nxt_cnt;
  logic          held;
  logic          rpt;

  assign cur_cnt = rise ? '0 : hold_cnt;
  assign nxt_cnt = (cur_cnt >= LAST) ? DLY : cur_cnt + CW'(1);
  assign held    = adjust & btn & (rise | active);
  assign rpt     = held & ~inhibit & (cur_cnt == DLY);
  assign step    = rise | rpt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q    <= 1'b0;
      active   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      btn_q    <= btn;
      active   <= held;
      hold_cnt <= held ? nxt_cnt : '0;
    end
  end
`else
  logic unused;
  assign unused = ^{adjust, inhibit};
  assign step   = rise;

  always_ff @(posedge clk) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn;
  end
`endif

endmodule

// File: rtl/time_unit_counter.sv
// Modulo counter for one clock/calendar field with runtime upper bound,
// clamping when the bound drops, and button-driven adjust.
// Optional auto-repeat of held buttons: define AUTO_REPEAT_EN.
//   clk_1Hz : sole clock
//   rst_n   : synchronous active-low reset
//   bus     : time_unit_counter_if.slave (controls in, value/carry/at_max out)
module time_unit_counter
  import time_pkg::*;
#(
  parameter int WIDTH         = 5,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 23,
  parameter int RESET_VAL     = 0,
  parameter int REPEAT_DELAY  = 4,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic                clk_1Hz,
  input  logic                rst_n,
  time_unit_counter_if.slave  bus
);

  if (!(MIN_VAL >= 0 && MIN_VAL <= RESET_VAL && RESET_VAL <= MAX_VAL &&
        MAX_VAL < (2 ** WIDTH))) begin : g_bad_range
    $error("time_unit_counter: need MIN_VAL <= RESET_VAL <= MAX_VAL < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] value_q;
  logic             carry_q;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] eff_max;
  logic             up_step;
  logic             down_step;
  mode_e            mode;

  assign mode = mode_e'(bus.adjust);

  always_comb begin
    lim     = (bus.dyn_max < MAX_V) ? bus.dyn_max : MAX_V;
    eff_max = (lim < MIN_V) ? MIN_V : lim;
  end

  btn_step_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
    .clk     (clk_1Hz),
    .rst_n   (rst_n),
    .btn     (bus.up),
    .adjust  (bus.adjust),
    .inhibit (bus.down),
    .step    (up_step)
  );

  btn_step_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
    .clk     (clk_1Hz),
    .rst_n   (rst_n),
    .btn     (bus.down),
    .adjust  (bus.adjust),
    .inhibit (bus.up),
    .step    (down_step)
  );

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      value_q <= RST_V;
      carry_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (mode == MODE_COUNT) begin
        if (bus.en_1 && bus.carry_in) begin
          if (value_q >= eff_max) begin
            value_q <= MIN_V;
            carry_q <= 1'b1;
          end else begin
            value_q <= value_q + WIDTH'(1);
          end
        end else if (value_q > eff_max) begin
          value_q <= eff_max;
        end
      end else begin
        // Carries from below are dropped while adjusting.
        if (up_step && !down_step) begin
          value_q <= (value_q >= eff_max) ? MIN_V : value_q + WIDTH'(1);
        end else if (down_step && !up_step) begin
          value_q <= (value_q <= MIN_V) ? eff_max : value_q - WIDTH'(1);
        end else if (value_q > eff_max) begin
          value_q <= eff_max;
        end
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.carry_out = carry_q;
  assign bus.at_max    = (value_q == eff_max);

endmodule

// File: tb/tb_time_unit_counter.sv
module tb_time_unit_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  time_unit_counter_if #(.WIDTH(5)) ia ();
  time_unit_counter_if #(.WIDTH(5)) ib ();

  time_unit_counter #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .RESET_VAL(0),
                      .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_a (
    .clk_1Hz (clk),
    .rst_n   (rst_n),
    .bus     (ia.slave)
  );

  time_unit_counter #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(1),
                      .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_b (
    .clk_1Hz (clk),
    .rst_n   (rst_n),
    .bus     (ib.slave)
  );

  typedef struct {
    bit         sel;   // 0 = instance A, 1 = instance B
    logic [4:0] v;
    logic       c;
    logic       m;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock once, pop and compare.
  task automatic tick(input string tag, input bit sel, input logic [4:0] v,
                      input logic c, input logic m);
    exp_t e;
    q.push_back('{sel: sel, v: v, c: c, m: m});
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.sel == 1'b0) begin
      chk({tag, ".val"}, ia.value, e.v);
      chk({tag, ".carry"}, {4'b0, ia.carry_out}, {4'b0, e.c});
      chk({tag, ".at_max"}, {4'b0, ia.at_max}, {4'b0, e.m});
    end else begin
      chk({tag, ".val"}, ib.value, e.v);
      chk({tag, ".carry"}, {4'b0, ib.carry_out}, {4'b0, e.c});
      chk({tag, ".at_max"}, {4'b0, ib.at_max}, {4'b0, e.m});
    end
  endtask

  initial begin
    logic [4:0] ev;
    rst_n = 1'b0;
    ia.en_1 = 0; ia.carry_in = 0; ia.adjust = 0; ia.up = 0; ia.down = 0; ia.dyn_max = 5'd23;
    ib.en_1 = 0; ib.carry_in = 0; ib.adjust = 0; ib.up = 0; ib.down = 0; ib.dyn_max = 5'd31;

    // reset
    tick("a_reset", 0, 5'd0, 0, 0);
    chk("b_reset.val", ib.value, 5'd1);
    chk("b_reset.carry", {4'b0, ib.carry_out}, 5'd0);

    // down at MIN wraps to eff_max; button held at reset release is an edge
    rst_n = 1'b1; ia.adjust = 1; ia.down = 1;
    tick("a_dn_wrap", 0, 5'd23, 0, 1);
    ia.down = 0;
    tick("a_dn_rel", 0, 5'd23, 0, 1);

    // count wrap 23 -> 0 with one-cycle carry
    ia.adjust = 0; ia.en_1 = 1; ia.carry_in = 1;
    tick("a_wrap", 0, 5'd0, 1, 0);
    ia.en_1 = 0;
    tick("a_wrap_next", 0, 5'd0, 0, 0);
    ia.en_1 = 1; ia.carry_in = 0;
    tick("a_no_cin", 0, 5'd0, 0, 0);
    ia.carry_in = 1;
    tick("a_inc", 0, 5'd1, 0, 0);

    // adjust: down 1->0, down 0->23, up 23->0, down 0->23
    ia.en_1 = 0; ia.carry_in = 0; ia.adjust = 1;
    ia.down = 1; tick("a_adj_dn1", 0, 5'd0, 0, 0);
    ia.down = 0; tick("a_adj_dn1r", 0, 5'd0, 0, 0);
    ia.down = 1; tick("a_adj_dn0", 0, 5'd23, 0, 1);
    ia.down = 0; tick("a_adj_dn0r", 0, 5'd23, 0, 1);
    ia.up = 1;   tick("a_adj_up23", 0, 5'd0, 0, 0);
    ia.up = 0;   tick("a_adj_up23r", 0, 5'd0, 0, 0);
    ia.down = 1; tick("a_adj_dn0b", 0, 5'd23, 0, 1);
    ia.down = 0; tick("a_adj_dn0br", 0, 5'd23, 0, 1);

    // carries dropped in adjust
    ia.en_1 = 1; ia.carry_in = 1;
    tick("a_adj_cin", 0, 5'd23, 0, 1);
    ia.en_1 = 0; ia.carry_in = 0;

    // both rising together: no change
    ia.up = 1; ia.down = 1; tick("a_both", 0, 5'd23, 0, 1);
    ia.up = 0; ia.down = 0; tick("a_both_rel", 0, 5'd23, 0, 1);

    // step up to 5
    ia.up = 1; tick("a_to0", 0, 5'd0, 0, 0);
    ia.up = 0; tick("a_to0r", 0, 5'd0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      ia.up = 1; tick("a_step", 0, 5'(i), 0, 0);
      ia.up = 0; tick("a_step_rel", 0, 5'(i), 0, 0);
    end

    // up held 10 cycles from value 5
    ia.up = 1;
    for (int k = 0; k < 10; k++) begin
`ifdef AUTO_REPEAT_EN
      ev = 5'd6 + 5'(k >= 4) + 5'(k >= 6) + 5'(k >= 8);
`else
      ev = 5'd6;
`endif
      tick("a_hold", 0, ev, 0, 0);
    end
    ia.up = 0;
`ifdef AUTO_REPEAT_EN
    tick("a_hold_rel", 0, 5'd9, 0, 0);
`else
    tick("a_hold_rel", 0, 5'd6, 0, 0);
`endif

    // reset beats a count event; up held through release steps once
    ia.adjust = 0; ia.en_1 = 1; ia.carry_in = 1; ia.up = 1; rst_n = 1'b0;
    tick("a_rst_cnt", 0, 5'd0, 0, 0);
    rst_n = 1'b1; ia.en_1 = 0; ia.carry_in = 0; ia.adjust = 1;
    tick("a_rst_up", 0, 5'd1, 0, 0);
    tick("a_rst_up_hold", 0, 5'd1, 0, 0);
    ia.up = 0;
    tick("a_rst_up_rel", 0, 5'd1, 0, 0);

    // instance B: MIN 1, MAX 31, clamping on dyn_max drop
    ib.adjust = 1; ib.down = 1;
    tick("b_dn_wrap", 1, 5'd31, 0, 1);
    ib.down = 0; ib.adjust = 0;
    tick("b_idle", 1, 5'd31, 0, 1);
    ib.dyn_max = 5'd30;
    tick("b_clamp", 1, 5'd30, 0, 1);
    ib.en_1 = 1; ib.carry_in = 1;
    tick("b_wrap", 1, 5'd1, 1, 0);
    ib.en_1 = 0;
    tick("b_wrap_next", 1, 5'd1, 0, 0);
    ib.dyn_max = 5'd0;
    tick("b_dyn0", 1, 5'd1, 0, 1);
    ib.en_1 = 1;
    tick("b_dyn0_wrap", 1, 5'd1, 1, 1);
    ib.dyn_max = 5'd31;
    tick("b_inc", 1, 5'd2, 0, 0);
    ib.en_1 = 0; ib.carry_in = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
